// File: rtl/field_alu.sv
// Nibble-serial field arithmetic unit for Saturn register fields.
// Walks the selected nibbles low to high, one per clock, applying
// ADD/SUB/INC/DEC in hex or BCD with the carry rippling between nibbles.
// Nibbles outside the field keep the value of operand A.
//
// state | meaning
// IDLE  | waiting for start; result/carry hold the last completed operation
// RUN   | processing nibble idx; count nibbles remain after this one
module field_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        dec_mode,
    input  logic [3:0]  nibble_start,
    input  logic [3:0]  nibble_width,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] result,
    output logic        carry
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [1:0]  op_q;
    logic        dec_q;
    logic [3:0]  idx;
    logic [3:0]  count;
    logic [63:0] b_q;
    logic        c;

    logic [5:0]  bit_pos;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [4:0]  sum;
    logic [4:0]  sum_m10;
    logic [4:0]  need;
    logic [4:0]  diff;
    logic        borrow;
    logic [3:0]  nib_out;
    logic        nib_co;

    // Per-nibble arithmetic on the current field nibble. Operand A is read
    // back from result, which was loaded with A at start and whose nibbles
    // are each overwritten exactly once, after they have been consumed.
    always_comb begin
        bit_pos = {idx, 2'b00};
        x       = result[bit_pos +: 4];
        y       = op_q[1] ? 4'h0 : b_q[bit_pos +: 4];
        sum     = {1'b0, x} + {1'b0, y} + {4'b0000, c};
        sum_m10 = sum - 5'd10;
        need    = {1'b0, y} + {4'b0000, c};
        diff    = {1'b0, x} - need;
        borrow  = ({1'b0, x} < need);
        nib_out = 4'h0;
        nib_co  = 1'b0;
        if (!op_q[0]) begin
            if (dec_q) begin
                if (sum > 5'd9) begin
                    nib_out = sum_m10[3:0];
                    nib_co  = 1'b1;
                end else begin
                    nib_out = sum[3:0];
                    nib_co  = 1'b0;
                end
            end else begin
                nib_out = sum[3:0];
                nib_co  = sum[4];
            end
        end else begin
            nib_co = borrow;
            // BCD borrow: x+10-y-c mod 16 equals (x-y-c mod 16) + 10 mod 16
            if (dec_q && borrow) begin
                nib_out = diff[3:0] + 4'd10;
            end else begin
                nib_out = diff[3:0];
            end
        end
    end

    // Control FSM: latch the request, then step one nibble per clock with a
    // down-counter on the remaining field length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= 2'b00;
            dec_q  <= 1'b0;
            idx    <= 4'h0;
            count  <= 4'h0;
            b_q    <= 64'h0;
            c      <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 64'h0;
            carry  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q   <= op;
                        dec_q  <= dec_mode;
                        b_q    <= b;
                        result <= a;
                        idx    <= nibble_start;
                        count  <= nibble_width;
                        c      <= op[1];
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    result[bit_pos +: 4] <= nib_out;
                    c   <= nib_co;
                    idx <= idx + 4'd1;
                    if (count == 4'h0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        carry <= nib_co;
                        state <= IDLE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_field_alu.sv
// Testbench for field_alu: directed cases plus randomized operations checked
// against a digit-by-digit arithmetic reference model.
module tb_field_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        dec_mode = 1'b0;
    logic [3:0]  nibble_start = 4'h0;
    logic [3:0]  nibble_width = 4'h0;
    logic [63:0] a = 64'h0;
    logic [63:0] b = 64'h0;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        carry;

    int   n_assert = 0;
    int   n_fail = 0;
    logic last_carry = 1'b0;

    field_alu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (op),
        .dec_mode     (dec_mode),
        .nibble_start (nibble_start),
        .nibble_width (nibble_width),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .carry        (carry)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: treat the field as a sequence of digits, do schoolbook
    // add/subtract in radix 16 or 10 with integer arithmetic.
    task automatic model(input logic [1:0] m_op, input logic m_dec, input int ns, input int nw,
                         input logic [63:0] ma, input logic [63:0] mb,
                         output logic [63:0] r, output logic co);
        int cy;
        int xv;
        int yv;
        int s;
        int o;
        int p;
        r  = ma;
        cy = m_op[1] ? 1 : 0;
        for (int i = 0; i <= nw; i++) begin
            p  = (ns + i) % 16;
            xv = int'(ma[p*4 +: 4]);
            yv = m_op[1] ? 0 : int'(mb[p*4 +: 4]);
            if (m_op[0] == 1'b0) begin
                s = xv + yv + cy;
                if (m_dec) begin
                    if (s > 9) begin o = (s - 10) % 16; cy = 1; end
                    else begin o = s; cy = 0; end
                end else begin
                    o  = s % 16;
                    cy = s / 16;
                end
            end else begin
                if (xv < yv + cy) begin
                    o  = m_dec ? (xv + 10 - yv - cy) % 16 : (xv + 16 - yv - cy) % 16;
                    cy = 1;
                end else begin
                    o  = xv - yv - cy;
                    cy = 0;
                end
            end
            r[p*4 +: 4] = 4'(o);
        end
        co = (cy != 0);
    endtask

    task automatic launch(input logic [1:0] l_op, input logic l_dec, input logic [3:0] ns,
                          input logic [3:0] nw, input logic [63:0] la, input logic [63:0] lb);
        op = l_op; dec_mode = l_dec; nibble_start = ns; nibble_width = nw; a = la; b = lb;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", {63'b0, busy}, 64'd1);
        chk("start_done", {63'b0, done}, 64'd0);
        chk("start_result_reload", result, la);
        chk("start_carry_hold", {63'b0, carry}, {63'b0, last_carry});
    endtask

    // Waits for done (bounded) and checks latency, busy, result and carry.
    task automatic finish_op(input string tag, input int exp_lat,
                             input logic [63:0] exp_r, input logic exp_c);
        int lat;
        bit busy_ok;
        lat = 0;
        busy_ok = 1'b1;
        while (lat < 40) begin
            tick();
            lat++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy_held"}, {63'b0, busy_ok}, 64'd1);
        chk({tag, "_busy_fall"}, {63'b0, busy}, 64'd0);
        chk({tag, "_result"}, result, exp_r);
        chk({tag, "_carry"}, {63'b0, carry}, {63'b0, exp_c});
        last_carry = exp_c;
    endtask

    initial begin
        logic [63:0] er;
        logic        ec;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [1:0]  rop;
        logic        rdec;
        logic [3:0]  rns;
        logic [3:0]  rnw;

        // Reset state
        #12;
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_done", {63'b0, done}, 64'd0);
        chk("reset_result", result, 64'h0);
        chk("reset_carry", {63'b0, carry}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Hex INC over five nibbles
        launch(2'b10, 1'b0, 4'd0, 4'd4, 64'h0000_0000_00FF_FFFF, 64'h1234);
        finish_op("hex_inc", 5, 64'h0000_0000_00F0_0000, 1'b1);
        tick();
        chk("done_one_cycle", {63'b0, done}, 64'd0);
        chk("result_hold", result, 64'h0000_0000_00F0_0000);

        // BCD add, then the same operands in hex
        launch(2'b00, 1'b1, 4'd0, 4'd3, 64'h0199, 64'h0001);
        finish_op("bcd_add", 4, 64'h0200, 1'b0);
        tick();
        launch(2'b00, 1'b0, 4'd0, 4'd3, 64'h0199, 64'h0001);
        finish_op("hex_add", 4, 64'h019A, 1'b0);
        tick();

        // BCD subtract with borrow out
        launch(2'b01, 1'b1, 4'd0, 4'd3, 64'h0, 64'h1);
        finish_op("bcd_sub", 4, 64'h9999, 1'b1);
        tick();

        // Hex DEC of the full word
        launch(2'b11, 1'b0, 4'd0, 4'd15, 64'h0, 64'h0);
        finish_op("hex_dec_full", 16, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        tick();

        // Non-BCD digits in BCD mode: F+F -> 4 carry 1
        launch(2'b00, 1'b1, 4'd2, 4'd0, 64'h0F00, 64'h0F00);
        finish_op("bcd_nondigit", 1, 64'h0400, 1'b1);
        tick();

        // Field wrapping past nibble 15
        launch(2'b10, 1'b0, 4'd14, 4'd3, 64'hFF12_3456_789A_BCFF, 64'h0);
        finish_op("wrap_inc", 4, 64'h0012_3456_789A_BC00, 1'b1);
        tick();

        // Start while busy is ignored; start in the done cycle is accepted
        model(2'b00, 1'b0, 3, 7, 64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, er, ec);
        launch(2'b00, 1'b0, 4'd3, 4'd7, 64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444);
        tick();
        tick();
        op = 2'b01; a = 64'hDEAD_BEEF_0000_1111; b = 64'h5; start = 1'b1;
        tick();
        start = 1'b0;
        finish_op("ignored_start", 5, er, ec);
        launch(2'b01, 1'b1, 4'd0, 4'd1, 64'h0042, 64'h0017);
        finish_op("done_cycle_start", 2, 64'h0025, 1'b0);
        tick();

        // Asynchronous reset in the middle of an operation
        launch(2'b00, 1'b0, 4'd0, 4'd7, 64'hFFFF_FFFF, 64'h1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", {63'b0, busy}, 64'd0);
        chk("midreset_done", {63'b0, done}, 64'd0);
        chk("midreset_carry", {63'b0, carry}, 64'd0);
        chk("midreset_result", result, 64'h0);
        last_carry = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("postreset_idle", {63'b0, busy | done}, 64'd0);
        launch(2'b00, 1'b0, 4'd0, 4'd0, 64'h5, 64'h4);
        finish_op("postreset_add", 1, 64'h9, 1'b0);
        tick();

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            rop  = 2'($urandom_range(0, 3));
            rdec = 1'($urandom_range(0, 1));
            rns  = 4'($urandom_range(0, 15));
            rnw  = 4'($urandom_range(0, 15));
            if (rdec && $urandom_range(0, 1) == 1) begin
                ra = ra & 64'h7777_7777_7777_7777;
                rb = rb & 64'h1111_1111_1111_1111;
            end
            model(rop, rdec, int'(rns), int'(rnw), ra, rb, er, ec);
            launch(rop, rdec, rns, rnw, ra, rb);
            a = ~ra;
            b = ~rb;
            finish_op("random", int'(rnw) + 1, er, ec);
            if (i % 2 == 0) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/field_alu.md
Name: field_alu

Overview:
- Nibble-serial arithmetic unit for Saturn register fields. It takes the same field descriptor used by the mask generator (nibble_start, nibble_width).
- It walks the selected nibbles one per clock, low to high, and applies ADD/SUB/INC/DEC in hex or BCD. Carry ripples between nibbles.
- It returns a 64-bit result: nibbles outside the field equal operand A.
- Sits directly downstream of the field mask stage, in the register-file write path.

Parameters:
- none. Width is fixed: 64-bit word, 16 nibbles, 4-bit nibble index.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request. Sampled on clk rising edge; accepted only when busy=0.
- op  input  2  operation: 00 A+B, 01 A-B, 10 A+1, 11 A-1. B is ignored for 10/11.
- dec_mode  input  1  1 = BCD per nibble, 0 = hex.
- nibble_start  input  4  first nibble index of the field.
- nibble_width  input  4  field length minus 1 (0 = one nibble, 15 = 16 nibbles).
- a  input  64  operand A.
- b  input  64  operand B.
- busy  output  1  high while nibbles are being processed.
- done  output  1  one-cycle pulse; result and carry are valid from this cycle on.
- result  output  64  A with the field nibbles replaced by the arithmetic result.
- carry  output  1  final carry (add) or borrow (sub) out of the last field nibble.

Behaviour:
- Single clock domain, one clock.
- Reset: asynchronous, active-low. While rst_n=0: busy=0, done=0, carry=0, result=0, FSM=IDLE, internal counters/latches=0.
- Reset mid-operation aborts the operation; no partial completion is flagged.
- FSM states: IDLE, RUN.
  - IDLE: when start=1 at edge k:
    - latch op, dec_mode, nibble_start, nibble_width, a, b;
    - result<=a; nibble index idx<=nibble_start; count<=nibble_width;
    - carry-in c<=1 for op 10/11, else 0;
    - busy<=1; go to RUN.
  - RUN: each edge, process nibble idx (arithmetic below):
    - result[idx]<=computed nibble; c<=carry out;
    - idx<=idx+1 mod 16 (wraps 15->0);
    - if count==0: busy<=0, done<=1, carry<=c_out, go to IDLE; else count<=count-1.
- Latency: start at edge k; nibbles processed at edges k+1..k+W+1 (W = nibble_width); done high in the cycle after edge k+W+1.
- done:
  - high exactly one cycle;
  - busy falls in the same cycle;
  - done is 0 in every other cycle.
- result and carry hold until the next accepted start. At that start, result reloads with a and carry is unchanged until completion.
- start while busy=1 is ignored; no queueing. start in the done cycle (busy=0) is accepted.
- Operand inputs may change freely after acceptance; only latched copies are used.
- Per-nibble arithmetic (x = A nibble; y = B nibble for op 00/01, y=0 for 10/11; c = carry/borrow in):
  - add, hex: s=x+y+c (5 bits); out=s[3:0]; c_out=s[4].
  - add, BCD: s=x+y+c; if s>9 then out=(s-10)[3:0], c_out=1; else out=s[3:0], c_out=0.
  - sub, hex: d=x-y-c; out=d mod 16; c_out=1 if x<y+c.
  - sub, BCD: if x<y+c then out=(x+10-y-c)[3:0], c_out=1; else out=x-y-c, c_out=0.
  - Non-BCD digits in BCD mode follow these formulas exactly. Example: add F+F+0 -> s=30 -> out=4, c_out=1.
- Field wrap-around: a field with nibble_start+nibble_width>15 continues at nibble 0. Carry propagates across the 15->0 boundary.
- busy=1 for exactly W+1 cycles per operation.

Test Plan:
- Hex INC, start=0, width=4, a=64'h0000_0000_00FF_FFFF -> result=64'h0000_0000_00F0_0000, carry=1. done is high in the 5th cycle after the start edge and lasts one cycle; busy is high for 5 cycles.
- BCD ADD, start=0, width=3, a=64'h0199, b=64'h0001 -> result=64'h0200, carry=0. Repeat with dec_mode=0 -> result=64'h019A, carry=0.
- BCD SUB borrow, start=0, width=3, a=0, b=64'h1 -> result=64'h9999, carry=1. Hex DEC full word (width=15) of a=0 -> result=all F, carry=1, busy for 16 cycles.
- Wrap, INC, start=14, width=3, a=64'hFF12_3456_789A_BCFF -> processing order 14,15,0,1; result=64'h0012_3456_789A_BC00, carry=1.
- Start during busy: second start (op=01, different a) 2 cycles after the first is ignored; the first result is unchanged. start asserted in the done cycle is accepted, with busy=1 next cycle.
- Reset mid-op: rst_n low asynchronously at cycle 2 of a width-7 op -> busy, done, carry and result are 0 immediately. After release, a new width-0 op a=5, b=4 hex ADD -> result=9, carry=0, done after 1 cycle.
